ball_ctrl: RTL and testbench
============================

# ball_ctrl

Single-player pong ball engine for the 640x480 VGA game. It consumes the paddle's `paddle_top` position and serve/tick timing, moves an 8x8 ball once per 60 Hz refresh tick, and bounces it off the top, bottom and left walls and the paddle. It emits the ball position, hit/miss pulses and a score count to the pixel renderer and score display.

## Interface
- `TICK_DIV`, 1666667: clock cycles per refresh tick (100 MHz / 60 Hz).
- `V`, 2: ball speed in pixels per tick, per axis.
- `MISS_TICKS`, 60: ticks the ball stays hidden after a miss.
- `clk` in 1: system clock, 100 MHz.
- `reset_n` in 1: reset, asynchronous, active-low.
- `paddle_top` in 10: top row of the paddle (paddle height 72).
- `serve` in 1: level-sensitive serve request.
- `ball_x` out 10: left column of the ball.
- `ball_y` out 10: top row of the ball.
- `ball_on` out 1: high only in PLAY; the renderer draws the ball only when high.
- `hit` out 1: one-clock pulse on a paddle hit.
- `miss` out 1: one-clock pulse when the ball passes the paddle.
- `score` out 8: paddle hit count, saturates at 255.

## Operation
- Tick generator: `count` runs 0..TICK_DIV-1 and wraps to 0. `tick` is high for one clock when `count == TICK_DIV-1`. All state and positions change only on tick clocks, except `hit`/`miss` clearing and the tick counter itself.
- States:
  - SERVE: ball at (316,236), dx=+, dy=+. On a tick with `serve`=1, go to PLAY. No motion on that tick.
  - PLAY: one move per tick, as below.
  - MISS: hold for MISS_TICKS ticks, then go to SERVE, reload the centre position and directions, and keep `score`.
- PLAY step, evaluated on the current position, with direction updates applied before the move:
  1. Top: if dy=- and `ball_y` < V, set dy=+.
  2. Bottom: if dy=+ and `ball_y` > 480-8-V, set dy=-.
  3. Left wall (columns 32..35): if dx=- and `ball_x` <= 35+V, set dx=+.
  4. Paddle (columns 600..603): a hit requires dx=+, `ball_x`+7 >= 600, `ball_x` <= 603, `ball_y`+7 >= `paddle_top` and `ball_y` <= `paddle_top`+71. On a hit: set dx=-, pulse `hit`, increment `score`.
  5. Miss: if there is no hit and `ball_x` > 632, pulse `miss`, go to MISS, and leave the position unchanged.
  6. Otherwise, `ball_x` ±= V and `ball_y` ±= V using the new directions.
- Vertical and horizontal flips are independent; a corner flips both on the same tick.
- A paddle hit takes priority over a miss.
- All arithmetic is 10-bit unsigned. The bounce thresholds guarantee no underflow or overflow.
- `paddle_top` is sampled combinationally on the tick clock. It is not registered here.

## Timing
- Reset values: `ball_x`=316, `ball_y`=236, dx=+, dy=+, `ball_on`=0, `hit`=0, `miss`=0, `score`=0, state SERVE, `count`=0.
- `reset_n` low mid-operation returns every register to its reset value immediately (asynchronous).
- Every output is registered and updates on the tick clock edge. `hit`/`miss` are high for exactly the one clock after that edge.
- Serve latency: first movement happens on the tick after the SERVE→PLAY transition.
- Miss hold: `ball_on` is low for MISS_TICKS ticks; SERVE is entered on tick MISS_TICKS after the miss.

## Configuration
- `BALL_SPEEDUP_EN` defined: the speed register starts at V. It increments by 1 after every 4th hit (score mod 4 = 0), saturates at V+2, and reloads to V on entry to SERVE. The wall thresholds use the current speed.
- `BALL_SPEEDUP_EN` undefined: speed is constant V. No speed register exists.

## Structure
- Shared package `pong_pkg` holds:
  - screen size 640/480;
  - wall columns 32/35;
  - paddle columns 600/603;
  - paddle height 72;
  - ball size 8;
  - serve position 316/236;
  - the state enum SERVE/PLAY/MISS.
- Sub-module `tick_gen` (parameter TICK_DIV, outputs `tick`) is shared with the paddle logic.

## Test plan
All scenarios use `TICK_DIV`=4.
- Reset, then `serve`=1: first tick enters PLAY with `ball_on`=1; the next tick gives (318,238).
- Free run: after 118 moves, `ball_y`=472. The next tick flips dy and gives `ball_y`=470 with `ball_x`=554.
- `paddle_top`=408: the tick at `ball_x`=594, `ball_y`=430 gives `hit` for 1 clock, `score`=1, and `ball_x`=592.
- `paddle_top`=0: at `ball_x`=634, the tick gives `miss` for 1 clock and `ball_on`=0. After 60 ticks the ball returns to (316,236) in SERVE.
- Ball returning from the paddle: at `ball_x`=36 with dx=-, the tick sets dx=+ and `ball_x`=38.
- `reset_n` asserted mid-PLAY: all outputs return to reset values in the same cycle. With `BALL_SPEEDUP_EN`, the 4th hit makes the step size 3.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants and types for the pong game: screen geometry, wall and
// paddle columns, ball size, serve position and the ball state machine.
package pong_pkg;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;
  localparam logic [9:0] WALL_L   = 10'd32;
  localparam logic [9:0] WALL_R   = 10'd35;
  localparam logic [9:0] PAD_L    = 10'd600;
  localparam logic [9:0] PAD_R    = 10'd603;
  localparam logic [9:0] PAD_H    = 10'd72;
  localparam logic [9:0] BALL_SZ  = 10'd8;
  localparam logic [9:0] SERVE_X  = 10'd316;
  localparam logic [9:0] SERVE_Y  = 10'd236;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2
  } ball_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Refresh tick generator: count runs 0..TICK_DIV-1 and tick is high for the
// one clock in which count is at its last value.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1666667
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          tick_s;

  // wrap detection and next count
  always_comb begin
    tick_s  = (count_q == LAST);
    count_d = tick_s ? '0 : count_q + CW'(1);
  end

  // counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball engine: serve/play/miss state machine moving an 8x8 ball once per
// refresh tick. Optional BALL_SPEEDUP_EN adds a speed register raised every 4th hit.
module ball_ctrl #(
  parameter int unsigned TICK_DIV   = 1666667,
  parameter int unsigned V          = 2,
  parameter int unsigned MISS_TICKS = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] paddle_top,
  input  logic       serve,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_on,
  output logic       hit,
  output logic       miss,
  output logic [7:0] score
);
  import pong_pkg::*;

  localparam logic [9:0]      STEP_V      = 10'(V);
  localparam int unsigned     MCW         = (MISS_TICKS > 1) ? $clog2(MISS_TICKS) : 1;
  localparam logic [MCW-1:0]  MISS_LAST   = MCW'(MISS_TICKS - 1);
  localparam logic [9:0]      BOTTOM_BASE = SCREEN_H - BALL_SZ;
  localparam logic [9:0]      MISS_X      = SCREEN_W - BALL_SZ;
  localparam logic [10:0]     BALL_EXT    = {1'b0, BALL_SZ - 10'd1};
  localparam logic [10:0]     PAD_SPAN    = {1'b0, PAD_H - 10'd1};

  logic            tick_s;
  ball_state_e     state_q, state_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic            dx_q, dx_d, dy_q, dy_d;
  logic            on_q, on_d, hit_q, hit_d, miss_q, miss_d;
  logic [7:0]      score_q, score_d;
  logic [MCW-1:0]  mcnt_q, mcnt_d;
  logic [9:0]      step_s;
  logic            paddle_hit_s, new_dx_s, new_dy_s;
  logic [7:0]      score_inc_s;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick_s)
  );

`ifdef BALL_SPEEDUP_EN
  localparam logic [9:0] STEP_MAX = 10'(V + 2);
  logic [9:0] speed_q, speed_d;
  assign step_s = speed_q;

  // speed register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      speed_q <= STEP_V;
    end else begin
      speed_q <= speed_d;
    end
  end
`else
  assign step_s = STEP_V;
`endif

  // bounce and paddle-contact decode on the current position
  always_comb begin
    paddle_hit_s = dx_q
                && (({1'b0, x_q} + BALL_EXT) >= {1'b0, PAD_L})
                && (x_q <= PAD_R)
                && (({1'b0, y_q} + BALL_EXT) >= {1'b0, paddle_top})
                && ({1'b0, y_q} <= ({1'b0, paddle_top} + PAD_SPAN));
    if (!dy_q && (y_q < step_s)) begin
      new_dy_s = 1'b1;
    end else if (dy_q && (y_q > (BOTTOM_BASE - step_s))) begin
      new_dy_s = 1'b0;
    end else begin
      new_dy_s = dy_q;
    end
    if (!dx_q && (x_q <= (WALL_R + step_s))) begin
      new_dx_s = 1'b1;
    end else if (paddle_hit_s) begin
      new_dx_s = 1'b0;
    end else begin
      new_dx_s = dx_q;
    end
    score_inc_s = sat_inc8(score_q);
  end

  // next state, motion and output pulses
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    score_d = score_q;
    mcnt_d  = mcnt_q;
`ifdef BALL_SPEEDUP_EN
    speed_d = speed_q;
`endif
    case (state_q)
      SERVE: begin
        if (tick_s && serve) begin
          state_d = PLAY;
        end else begin
          state_d = SERVE;
        end
      end
      PLAY: begin
        if (tick_s) begin
          dx_d = new_dx_s;
          dy_d = new_dy_s;
          if (paddle_hit_s) begin
            hit_d   = 1'b1;
            score_d = score_inc_s;
`ifdef BALL_SPEEDUP_EN
            if ((score_inc_s[1:0] == 2'd0) && (speed_q < STEP_MAX)) begin
              speed_d = speed_q + 10'd1;
            end else begin
              speed_d = speed_q;
            end
`endif
          end else begin
            score_d = score_q;
          end
          // a hit always wins over the miss column check
          if (!paddle_hit_s && (x_q > MISS_X)) begin
            miss_d  = 1'b1;
            state_d = MISS;
            mcnt_d  = '0;
          end else begin
            x_d = new_dx_s ? (x_q + step_s) : (x_q - step_s);
            y_d = new_dy_s ? (y_q + step_s) : (y_q - step_s);
          end
        end else begin
          state_d = PLAY;
        end
      end
      MISS: begin
        if (tick_s) begin
          if (mcnt_q == MISS_LAST) begin
            state_d = SERVE;
            x_d     = SERVE_X;
            y_d     = SERVE_Y;
            dx_d    = 1'b1;
            dy_d    = 1'b1;
`ifdef BALL_SPEEDUP_EN
            speed_d = STEP_V;
`endif
          end else begin
            mcnt_d = mcnt_q + MCW'(1);
          end
        end else begin
          state_d = MISS;
        end
      end
      default: begin
        state_d = SERVE;
      end
    endcase
    on_d = (state_d == PLAY);
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SERVE;
      x_q     <= SERVE_X;
      y_q     <= SERVE_Y;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      on_q    <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      score_q <= 8'd0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      on_q    <= on_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      score_q <= score_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign ball_x  = x_q;
  assign ball_y  = y_q;
  assign ball_on = on_q;
  assign hit     = hit_q;
  assign miss    = miss_q;
  assign score   = score_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: integer reference model of the ball rules feeding a
// scoreboard queue, a per-clock monitor, and directed scenario checks.
module tb_ball_ctrl;

  localparam int TD = 4;
  localparam int VV = 2;
  localparam int MT = 60;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] paddle_top = 10'd408;
  logic [9:0] ball_x, ball_y;
  logic       ball_on, hit, miss;
  logic [7:0] score;

  always #5 clk = ~clk;

  ball_ctrl #(.TICK_DIV(TD), .V(VV), .MISS_TICKS(MT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .paddle_top (paddle_top),
    .serve      (serve),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .ball_on    (ball_on),
    .hit        (hit),
    .miss       (miss),
    .score      (score)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       on;
    logic       hit;
    logic       miss;
    logic [7:0] score;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  // reference model: mode 0 = waiting to serve, 1 = in play, 2 = hidden after a miss
  int m_cnt, m_mode, m_x, m_y, m_vx, m_vy, m_score, m_mc, m_sp, m_ticks;
  bit m_hit, m_miss;
  bit rnd_serve = 1'b0;
  bit rnd_pt = 1'b0;

  function automatic void model_reset();
    m_cnt = 0; m_mode = 0; m_x = 316; m_y = 236; m_vx = 1; m_vy = 1;
    m_score = 0; m_mc = 0; m_sp = VV; m_hit = 1'b0; m_miss = 1'b0;
  endfunction

  function automatic void model_tick();
    int  pt;
    int  sp;
    bit  h;
    pt = int'(paddle_top);
    sp = m_sp;
    case (m_mode)
      0: if (serve) m_mode = 1;
      1: begin
        if (m_vy < 0 && m_y < sp) m_vy = 1;
        else if (m_vy > 0 && m_y > 480 - 8 - sp) m_vy = -1;
        if (m_vx < 0 && m_x <= 35 + sp) m_vx = 1;
        h = (m_vx > 0) && (m_x + 7 >= 600) && (m_x <= 603) && (m_y + 7 >= pt) && (m_y <= pt + 71);
        if (h) begin
          m_vx = -1;
          m_hit = 1'b1;
          if (m_score < 255) m_score++;
`ifdef BALL_SPEEDUP_EN
          if (m_score % 4 == 0 && m_sp < VV + 2) m_sp++;
`endif
        end
        if (!h && m_x > 632) begin
          m_miss = 1'b1;
          m_mode = 2;
          m_mc = 0;
        end else begin
          m_x += m_vx * sp;
          m_y += m_vy * sp;
        end
      end
      default: begin
        m_mc++;
        if (m_mc == MT) begin
          m_mode = 0; m_x = 316; m_y = 236; m_vx = 1; m_vy = 1; m_sp = VV;
        end
      end
    endcase
  endfunction

  function automatic void model_clock();
    if (!reset_n) begin
      model_reset();
    end else begin
      m_hit = 1'b0;
      m_miss = 1'b0;
      if (m_cnt == TD - 1) begin
        m_cnt = 0;
        m_ticks++;
        model_tick();
      end else begin
        m_cnt++;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t r;
    r.x = 10'(m_x);
    r.y = 10'(m_y);
    r.on = (m_mode == 1);
    r.hit = m_hit;
    r.miss = m_miss;
    r.score = 8'(m_score);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // one clock: drive inputs at the falling edge, predict the next rising edge
  task automatic cyc();
    @(negedge clk);
    if (rnd_serve) serve = ($urandom_range(0, 3) != 0);
    if (rnd_pt && $urandom_range(0, 15) == 0) paddle_top = 10'($urandom_range(0, 408));
    model_clock();
    exp_q.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  task automatic run_ticks(input int n);
    int target;
    int guard;
    target = m_ticks + n;
    guard = 0;
    while (m_ticks < target && guard < n * TD + 8) begin
      cyc();
      guard++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_x", int'(ball_x), 316);
    chk("async_rst_y", int'(ball_y), 236);
    chk("async_rst_on", int'(ball_on), 0);
    chk("async_rst_hit", int'(hit), 0);
    chk("async_rst_miss", int'(miss), 0);
    chk("async_rst_score", int'(score), 0);
    model_clock();
    exp_q.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  // scoreboard monitor: one expected record per rising edge
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if ({ball_x, ball_y, ball_on, hit, miss, score} !== mon_e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got x=%0d y=%0d on=%0b hit=%0b miss=%0b score=%0d, expected x=%0d y=%0d on=%0b hit=%0b miss=%0b score=%0d",
                 $time, ball_x, ball_y, ball_on, hit, miss, score,
                 mon_e.x, mon_e.y, mon_e.on, mon_e.hit, mon_e.miss, mon_e.score);
      end
    end
  end

  initial begin
    int g;
    model_reset();
    m_ticks = 0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    chk("reset_x", int'(ball_x), 316);
    chk("reset_y", int'(ball_y), 236);
    chk("reset_on", int'(ball_on), 0);
    chk("reset_score", int'(score), 0);

    run_ticks(3);
    chk("no_serve_on", int'(ball_on), 0);
    serve = 1'b1;
    run_ticks(1);
    chk("serve_on", int'(ball_on), 1);
    chk("serve_x_held", int'(ball_x), 316);
    run_ticks(1);
    chk("first_move_x", int'(ball_x), 318);
    chk("first_move_y", int'(ball_y), 238);

    rnd_serve = 1'b1;
    run_ticks(117);
    chk("bottom_y", int'(ball_y), 472);
    run_ticks(1);
    chk("bottom_flip_y", int'(ball_y), 470);
    chk("bottom_flip_x", int'(ball_x), 554);

    run_ticks(20);
    chk("pre_hit_x", int'(ball_x), 594);
    chk("pre_hit_y", int'(ball_y), 430);
    run_ticks(1);
    chk("hit_pulse", int'(hit), 1);
    chk("hit_score", int'(score), 1);
    chk("hit_x", int'(ball_x), 592);
    cyc();
    chk("hit_cleared", int'(hit), 0);

    run_ticks(278);
    chk("left_x", int'(ball_x), 36);
    run_ticks(1);
    chk("left_bounce_x", int'(ball_x), 38);

    paddle_top = 10'd0;
    g = 0;
    while (m_mode != 2 && g < 2000) begin
      cyc();
      g++;
    end
    chk("reach_miss_in_budget", int'(g < 2000), 1);
    chk("miss_pulse", int'(miss), 1);
    chk("miss_on", int'(ball_on), 0);
    chk("miss_x_held", int'(ball_x), 634);
    cyc();
    chk("miss_cleared", int'(miss), 0);
    run_ticks(59);
    chk("miss_hold_on", int'(ball_on), 0);
    chk("miss_hold_x", int'(ball_x), 634);
    run_ticks(1);
    chk("reserve_x", int'(ball_x), 316);
    chk("reserve_y", int'(ball_y), 236);
    chk("reserve_score", int'(score), 1);

    rnd_pt = 1'b1;
    repeat (3000) cyc();

    g = 0;
    while (m_mode != 1 && g < 2000) begin
      cyc();
      g++;
    end
    chk("reach_play_in_budget", int'(g < 2000), 1);
    run_ticks(5);
    pulse_reset();
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_rst_on", int'(ball_on), 0);
    repeat (3000) cyc();

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
